// File: rtl/simon_pkg.sv
// Shared constants, state type and word helpers for the Simon 32/64 encryptor.
package simon_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned KEY_WORDS  = 4;
  localparam int unsigned NUM_ROUNDS = 32;

  // z0[0] is the leftmost (MSB) bit of this literal.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic {StIdle, StRun} state_e;

  function automatic logic z0_bit(input logic [4:0] idx);
    logic [5:0] pos;
    pos = 6'd61 - {1'b0, idx};
    return Z0[pos];
  endfunction

  function automatic logic [WORD_W-1:0] rotl1(input logic [WORD_W-1:0] w);
    return {w[14:0], w[15]};
  endfunction

  function automatic logic [WORD_W-1:0] rotl2(input logic [WORD_W-1:0] w);
    return {w[13:0], w[15:14]};
  endfunction

  function automatic logic [WORD_W-1:0] rotl8(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic logic [WORD_W-1:0] rotr1(input logic [WORD_W-1:0] w);
    return {w[0], w[15:1]};
  endfunction

  function automatic logic [WORD_W-1:0] rotr3(input logic [WORD_W-1:0] w);
    return {w[2:0], w[15:3]};
  endfunction

  // Folds the ~k_i inversion and the ^16'h0003 into one mask: ~k ^ 3 ^ z == k ^ fffc ^ z.
  function automatic logic [WORD_W-1:0] key_const(input logic z);
    return 16'hfffc ^ {15'd0, z};
  endfunction

  function automatic logic [WORD_W-1:0] round_x(input logic [WORD_W-1:0] x,
                                                input logic [WORD_W-1:0] y,
                                                input logic [WORD_W-1:0] k);
    return y ^ (rotl1(x) & rotl8(x)) ^ rotl2(x) ^ k;
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// Combinational Simon 32/64 key-schedule step: produces k_{i+4} from k_i, k_{i+1}, k_{i+3}, z0[i].
module simon_key_step
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] i_k0,
  input  logic [WORD_W-1:0] i_k1,
  input  logic [WORD_W-1:0] i_k3,
  input  logic              i_z,
  output logic [WORD_W-1:0] o_k4
);

  logic [WORD_W-1:0] w_tmp0;
  logic [WORD_W-1:0] w_tmp1;

  assign w_tmp0 = rotr3(i_k3) ^ i_k1;
  assign w_tmp1 = w_tmp0 ^ rotr1(w_tmp0);
  assign o_k4   = i_k0 ^ w_tmp1 ^ key_const(i_z);

endmodule

// File: rtl/simon_newer.sv
// Iterative Simon 32/64 encryptor, one round per clock, round keys generated on the fly.
// Optional busy output enabled by defining SIMON_BUSY_PORT_EN.
module simon_newer
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [31:0] plain_text,
  output logic [31:0] cipher_text,
  output logic        done
`ifdef SIMON_BUSY_PORT_EN
  ,
  output logic        busy
`endif
);

  state_e                          r_state;
  state_e                          w_state_next;
  logic   [4:0]                    r_round;
  logic   [WORD_W-1:0]             r_x;
  logic   [WORD_W-1:0]             r_y;
  logic   [KEY_WORDS*WORD_W-1:0]   r_key;
  logic   [31:0]                   r_ct;
  logic                            r_done;

  logic                            w_accept;
  logic                            w_finish;
  logic   [WORD_W-1:0]             w_x_next;
  logic   [WORD_W-1:0]             w_k4;

  simon_key_step u_key_step (
    .i_k0 (r_key[15:0]),
    .i_k1 (r_key[31:16]),
    .i_k3 (r_key[63:48]),
    .i_z  (z0_bit(r_round)),
    .o_k4 (w_k4)
  );

  assign w_x_next = round_x(r_x, r_y, r_key[15:0]);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (r_round == 5'(NUM_ROUNDS - 1)) begin
          w_finish     = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_round <= 5'd0;
      r_x     <= '0;
      r_y     <= '0;
      r_key   <= '0;
      r_ct    <= 32'h0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      r_x     <= plain_text[31:16];
      r_y     <= plain_text[15:0];
      r_key   <= key;
      r_round <= 5'd0;
      r_done  <= 1'b0;
    end else if (r_state == StRun) begin
      // Key register slides one word per round so k_i is always the low word.
      r_x     <= w_x_next;
      r_y     <= r_x;
      r_key   <= {w_k4, r_key[63:16]};
      r_round <= r_round + 5'd1;
      if (w_finish) begin
        r_ct   <= {w_x_next, r_x};
        r_done <= 1'b1;
      end
    end
  end

  assign cipher_text = r_ct;
  assign done        = r_done;

`ifdef SIMON_BUSY_PORT_EN
  assign busy = (r_state == StRun);
`endif

endmodule

// File: tb/tb_simon_newer.sv
// Directed self-checking bench for simon_newer using published Simon 32/64 vectors.
module tb_simon_newer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] key;
  logic [31:0] plain_text;
  logic [31:0] cipher_text;
  logic        done;
`ifdef SIMON_BUSY_PORT_EN
  logic        busy;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_ct;

  simon_newer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .key         (key),
    .plain_text  (plain_text),
    .cipher_text (cipher_text),
    .done        (done)
`ifdef SIMON_BUSY_PORT_EN
    ,
    .busy        (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after an accept edge; checks latency, mid-run hold and result.
  task automatic wait_done(input string tag, input logic [31:0] exp, input logic [31:0] prev,
                           input bit disturb);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (disturb && n == 10) begin
        start      = 1'b1;
        key        = ~key;
        plain_text = ~plain_text;
      end
      if (disturb && n == 11) start = 1'b0;
      if (n == 16) begin
        check_eq({tag, "_mid_ct"}, {32'd0, cipher_text}, {32'd0, prev});
        check_eq({tag, "_mid_done"}, {63'd0, done}, 64'd0);
`ifdef SIMON_BUSY_PORT_EN
        check_eq({tag, "_mid_busy"}, {63'd0, busy}, 64'd1);
`endif
      end
    end while (!done && n < 40);
    check_eq({tag, "_latency"}, 64'(n), 64'd32);
    check_eq({tag, "_ct"}, {32'd0, cipher_text}, {32'd0, exp});
`ifdef SIMON_BUSY_PORT_EN
    check_eq({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
`endif
  endtask

  task automatic run_vec(input string tag, input logic [63:0] k, input logic [31:0] p,
                         input logic [31:0] exp, input bit disturb, input bit hold);
    key        = k;
    plain_text = p;
    start      = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    check_eq({tag, "_acc_done"}, {63'd0, done}, 64'd0);
    wait_done(tag, exp, prev_ct, disturb);
    prev_ct = exp;
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    key        = '0;
    plain_text = '0;
    prev_ct    = 32'h0;
    tick();
    tick();
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_ct", {32'd0, cipher_text}, 64'd0);
`ifdef SIMON_BUSY_PORT_EN
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
`endif
    reset = 1'b1;
    tick();

    // Five vectors back to back: each start is sampled on the edge after done.
    run_vec("v1", 64'h1918111009080100, 32'h65656877, 32'hc69be9bb, 1'b0, 1'b0);
    run_vec("v2", 64'hae4f4b3f2bea21bb, 32'hb94dd41b, 32'h8494f458, 1'b0, 1'b0);
    run_vec("v3", 64'h09586108cdaade2c, 32'h9d09da8b, 32'hdeb4c76b, 1'b0, 1'b0);
    run_vec("v4", 64'ha1f6a78d5886c60a, 32'h5be7b347, 32'hfc29a459, 1'b0, 1'b0);
    run_vec("v5", 64'hccc85d3d82b2d23a, 32'he8e18044, 32'h32294659, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("hold_done", {63'd0, done}, 64'd1);
      check_eq("hold_ct", {32'd0, cipher_text}, 64'h32294659);
    end

    run_vec("dist", 64'h1918111009080100, 32'h65656877, 32'hc69be9bb, 1'b1, 1'b0);

    // start held high: ignored on the done edge, accepted on the following idle edge.
    run_vec("held", 64'hae4f4b3f2bea21bb, 32'hb94dd41b, 32'h8494f458, 1'b0, 1'b1);
    tick();
    check_eq("held_reacc_done", {63'd0, done}, 64'd0);
    start = 1'b0;
    wait_done("held2", 32'h8494f458, 32'h8494f458, 1'b0);
    prev_ct = 32'h8494f458;

    // Abort mid-run with reset, with start asserted during reset.
    key        = 64'h09586108cdaade2c;
    plain_text = 32'h9d09da8b;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    check_eq("abort_done", {63'd0, done}, 64'd0);
    check_eq("abort_ct", {32'd0, cipher_text}, 64'd0);
    tick();
    check_eq("abort_done2", {63'd0, done}, 64'd0);
    reset   = 1'b1;
    start   = 1'b0;
    prev_ct = 32'h0;
    run_vec("post", 64'h1918111009080100, 32'h65656877, 32'hc69be9bb, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
